// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming min/max distance engine.
package hamming_pkg;

  localparam int OP_W      = 16;
  localparam int HD_W      = 5;
  localparam int HD_MAX    = 16;
  localparam int NUM_PAIRS = 496;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SCAN,
    WR_MIN,
    WR_MAX,
    WR_P0,
    WR_P1,
    WR_P2,
    WR_P3,
    DONE
  } state_t;

endpackage

// File: rtl/popcount16.sv
// Combinational ones count of a 16-bit word, result 0..16.
module popcount16
  import hamming_pkg::*;
(
  input  logic [OP_W-1:0] din,
  output logic [HD_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < OP_W; i++) begin
      cnt = cnt + HD_W'(din[i]);
    end
  end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Loads 32 operands from data memory, finds min/max pairwise Hamming distance,
// writes results back. HAMMING_PAIR_ADDR_EN also writes the winning pair indices.
module hamming_minmax_engine
  import hamming_pkg::*;
#(
  parameter int NUM_OPS  = 32,
  parameter int OP_BASE  = 0,
  parameter int RES_BASE = 64,
  parameter int AW       = 8,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rd_data,
  output logic          dm_wr_en,
  output logic [DW-1:0] dm_wr_data,
  output state_t        dbg_state
);

  localparam int IW = $clog2(NUM_OPS);
  localparam int BW = IW + 1;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   b_q, b_d;
  logic [IW-1:0]   j_q, j_d, k_q, k_d;
  logic [OP_W-1:0] cache_q [NUM_OPS];
  logic [OP_W-1:0] cache_d [NUM_OPS];
  logic [HD_W-1:0] min_q, min_d, max_q, max_d;
  logic [HD_W-1:0] hd;
`ifdef HAMMING_PAIR_ADDR_EN
  logic [IW-1:0]   min_j_q, min_j_d, min_k_q, min_k_d;
  logic [IW-1:0]   max_j_q, max_j_d, max_k_q, max_k_d;
`endif

  popcount16 u_popcount (
    .din (cache_q[j_q] ^ cache_q[k_q]),
    .cnt (hd)
  );

  // Handshake: start high arms the engine, the following start low launches a
  // run; done stays high until start rises again, which returns to IDLE armed.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    done_d  = done_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    b_d     = b_q;
    j_d     = j_q;
    k_d     = k_q;
    cache_d = cache_q;
    min_d   = min_q;
    max_d   = max_q;
`ifdef HAMMING_PAIR_ADDR_EN
    min_j_d = min_j_q;
    min_k_d = min_k_q;
    max_j_d = max_j_q;
    max_k_d = max_k_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = LOAD;
          armed_d = 1'b0;
          min_d   = HD_W'(HD_MAX);
          max_d   = '0;
          b_d     = '0;
          addr_d  = AW'(OP_BASE);
        end
      end
      LOAD: begin
        // Even byte address is the operand's high byte.
        if (b_q[0]) cache_d[b_q[BW-1:1]][7:0]  = dm_rd_data[7:0];
        else        cache_d[b_q[BW-1:1]][15:8] = dm_rd_data[7:0];
        b_d    = b_q + BW'(1);
        addr_d = AW'(OP_BASE) + AW'(b_q) + AW'(1);
        if (b_q == BW'(2 * NUM_OPS - 1)) begin
          state_d = SCAN;
          j_d     = '0;
          k_d     = IW'(1);
        end
      end
      SCAN: begin
        if (hd < min_q) begin
          min_d = hd;
`ifdef HAMMING_PAIR_ADDR_EN
          min_j_d = j_q;
          min_k_d = k_q;
`endif
        end
        if (hd > max_q) begin
          max_d = hd;
`ifdef HAMMING_PAIR_ADDR_EN
          max_j_d = j_q;
          max_k_d = k_q;
`endif
        end
        if (k_q == IW'(NUM_OPS - 1)) begin
          if (j_q == IW'(NUM_OPS - 2)) begin
            state_d = WR_MIN;
            wr_en_d = 1'b1;
            addr_d  = AW'(RES_BASE);
            wdata_d = DW'(min_d);
          end else begin
            j_d = j_q + IW'(1);
            k_d = j_q + IW'(2);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      WR_MIN: begin
        state_d = WR_MAX;
        wr_en_d = 1'b1;
        addr_d  = AW'(RES_BASE + 1);
        wdata_d = DW'(max_q);
      end
`ifdef HAMMING_PAIR_ADDR_EN
      WR_MAX: begin
        state_d = WR_P0;
        wr_en_d = 1'b1;
        addr_d  = AW'(RES_BASE + 2);
        wdata_d = DW'(min_k_q);
      end
      WR_P0: begin
        state_d = WR_P1;
        wr_en_d = 1'b1;
        addr_d  = AW'(RES_BASE + 3);
        wdata_d = DW'(min_j_q);
      end
      WR_P1: begin
        state_d = WR_P2;
        wr_en_d = 1'b1;
        addr_d  = AW'(RES_BASE + 4);
        wdata_d = DW'(max_k_q);
      end
      WR_P2: begin
        state_d = WR_P3;
        wr_en_d = 1'b1;
        addr_d  = AW'(RES_BASE + 5);
        wdata_d = DW'(max_j_q);
      end
      WR_P3: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`else
      WR_MAX: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
      DONE: begin
        if (start) begin
          state_d = IDLE;
          armed_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      b_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      min_q   <= HD_W'(HD_MAX);
      max_q   <= '0;
`ifdef HAMMING_PAIR_ADDR_EN
      min_j_q <= '0;
      min_k_q <= '0;
      max_j_q <= '0;
      max_k_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      b_q     <= b_d;
      j_q     <= j_d;
      k_q     <= k_d;
      min_q   <= min_d;
      max_q   <= max_d;
`ifdef HAMMING_PAIR_ADDR_EN
      min_j_q <= min_j_d;
      min_k_q <= min_k_d;
      max_j_q <= max_j_d;
      max_k_q <= max_k_d;
`endif
    end
  end

  // Operand cache is fully reloaded before every scan, so it needs no reset.
  always_ff @(posedge clk) begin
    cache_q <= cache_d;
  end

  assign done       = done_q;
  assign dm_wr_en   = wr_en_q;
  assign dm_addr    = addr_q;
  assign dm_wr_data = wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Bench for hamming_minmax_engine: table-driven runs against a behavioural data memory,
// plus idle, mid-run reset and back-to-back sequences.
module tb_hamming_minmax_engine;
  import hamming_pkg::*;

`ifdef HAMMING_PAIR_ADDR_EN
  localparam int LAT  = 64 + NUM_PAIRS + 6;
  localparam int NRES = 6;
`else
  localparam int LAT  = 64 + NUM_PAIRS + 2;
  localparam int NRES = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] dm_addr;
  logic [7:0] dm_rd_data;
  logic       dm_wr_en;
  logic [7:0] dm_wr_data;
  state_t     dbg_state;

  logic [15:0] op_mem [32];
  logic [7:0]  mem [256];
  logic        mem_clr;
  int          wr_cnt;
  int          bad_wr;
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    int          mode;
    logic [15:0] a;
    logic [15:0] b;
    bit          glitch;
    int          emin;
    int          emax;
    int          emnk;
    int          emnj;
    int          emxk;
    int          emxj;
  } vec_t;

  vec_t vecs [16];

  hamming_minmax_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .dm_addr    (dm_addr),
    .dm_rd_data (dm_rd_data),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Operands live in op_mem; the rest of the byte space is the result memory.
  assign dm_rd_data = (dm_addr < 8'd64) ?
                      (dm_addr[0] ? op_mem[dm_addr[5:1]][7:0] : op_mem[dm_addr[5:1]][15:8]) :
                      mem[dm_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      wr_cnt <= 0;
      bad_wr <= 0;
    end else if (dm_wr_en) begin
      mem[dm_addr] <= dm_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (dm_addr < 8'd64 || dm_addr >= 8'(64 + NRES)) bad_wr <= bad_wr + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_ops(input int mode, input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       op_mem[i] = (i % 2 == 0) ? a : b;
        1:       op_mem[i] = 16'h0001 << (i % 16);
        2:       op_mem[i] = 16'(i) ^ a;
        default: op_mem[i] = 16'($urandom_range(0, 65535));
      endcase
    end
  endtask

  task automatic model(output int mn, output int mx, output int mnk, output int mnj,
                       output int mxk, output int mxj);
    int d;
    mn = 16; mx = 0; mnk = 0; mnj = 0; mxk = 0; mxj = 0;
    for (int j = 0; j < 31; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = $countones(op_mem[j] ^ op_mem[k]);
        if (d < mn) begin mn = d; mnk = k; mnj = j; end
        if (d > mx) begin mx = d; mxk = k; mxj = j; end
      end
    end
  endtask

  // Start high for one edge, low on the next; returns edges counted after the launching edge.
  task automatic run_engine(input bit glitch, output int lat);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("done_low_after_start", int'(done), 0);
    @(posedge clk);
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (glitch && lat == 300) start = 1'b1;
      if (glitch && lat == 302) start = 1'b0;
      if (done) break;
    end
  endtask

  task automatic check_results(input int emin, input int emax, input int emnk, input int emnj,
                               input int emxk, input int emxj);
    check("res_min", int'(mem[64]), emin);
    check("res_max", int'(mem[65]), emax);
`ifdef HAMMING_PAIR_ADDR_EN
    check("res_min1", int'(mem[66]), emnk);
    check("res_min2", int'(mem[67]), emnj);
    check("res_max1", int'(mem[68]), emxk);
    check("res_max2", int'(mem[69]), emxj);
`else
    check("untouched_66_69", int'({mem[66], mem[67], mem[68], mem[69]} == 32'hEEEEEEEE), 1);
    check("unused_idx", emnk + emnj + emxk + emxj >= 0 ? 1 : 0, 1);
`endif
  endtask

  initial begin
    int lat, w0, emin, emax, emnk, emnj, emxk, emxj;
    logic [7:0] saved64, saved65;

    vecs[0] = '{0, 16'hA5A5, 16'hA5A5, 1'b0, 0, 0,  1, 0,  0, 0};
    vecs[1] = '{0, 16'h0000, 16'hFFFF, 1'b1, 0, 16, 2, 0,  1, 0};
    vecs[2] = '{0, 16'h0001, 16'h0003, 1'b0, 0, 1,  2, 0,  1, 0};
    vecs[3] = '{1, 16'h0000, 16'h0000, 1'b0, 0, 2,  16, 0, 1, 0};
    vecs[4] = '{2, 16'h0000, 16'h0000, 1'b0, 1, 5,  1, 0,  31, 0};
    vecs[5] = '{2, 16'hFF00, 16'h0000, 1'b0, 1, 5,  1, 0,  31, 0};
    for (int i = 6; i < 16; i++) vecs[i] = '{3, 16'h0, 16'h0, 1'b0, -1, -1, 0, 0, 0, 0};

    // Reset and reset values
    reset = 1'b1; start = 1'b0; mem_clr = 1'b1;
    fill_ops(0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_wr_en", int'(dm_wr_en), 0);
    check("rst_addr", int'(dm_addr), 0);
    check("rst_wr_data", int'(dm_wr_data), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    reset = 1'b0; mem_clr = 1'b0;

    // start held low from reset release: no run
    @(negedge clk);
    w0 = wr_cnt;
    repeat (1000) @(negedge clk);
    check("idle_no_writes", wr_cnt - w0, 0);
    check("idle_state", int'(dbg_state), int'(IDLE));
    check("idle_done", int'(done), 0);

    // Table-driven runs, each launched from the previous run's DONE
    for (int v = 0; v < 16; v++) begin
      fill_ops(vecs[v].mode, vecs[v].a, vecs[v].b);
      w0 = wr_cnt;
      run_engine(vecs[v].glitch, lat);
      check("latency", lat, LAT);
      check("write_count", wr_cnt - w0, NRES);
      if (vecs[v].emin < 0) begin
        model(emin, emax, emnk, emnj, emxk, emxj);
        check_results(emin, emax, emnk, emnj, emxk, emxj);
      end else begin
        check_results(vecs[v].emin, vecs[v].emax, vecs[v].emnk, vecs[v].emnj,
                      vecs[v].emxk, vecs[v].emxj);
      end
      repeat (3) @(negedge clk);
      check("done_holds", int'(done), 1);
    end
    check("no_stray_writes", bad_wr, 0);

    // Reset at SCAN cycle 200: results untouched, then a clean rerun
    saved64 = mem[64]; saved65 = mem[65];
    fill_ops(3, 16'h0, 16'h0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    repeat (64 + 200) @(posedge clk);
    #1;
    check("pre_reset_state", int'(dbg_state), int'(SCAN));
    reset = 1'b1;
    #1;
    check("midrst_done", int'(done), 0);
    check("midrst_wr_en", int'(dm_wr_en), 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_run", int'(dbg_state), int'(IDLE));
    check("midrst_mem64", int'(mem[64]), int'(saved64));
    check("midrst_mem65", int'(mem[65]), int'(saved65));
    run_engine(1'b0, lat);
    check("rerun_latency", lat, LAT);
    model(emin, emax, emnk, emnj, emxk, emxj);
    check_results(emin, emax, emnk, emnj, emxk, emxj);

    // Back-to-back: new operands, done drops on start high, results overwritten
    fill_ops(0, 16'h0000, 16'hFFFF);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    check("b2b_done_drop", int'(done), 0);
    check("b2b_idle", int'(dbg_state), int'(IDLE));
    start = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    check("b2b_latency", lat, LAT);
    check_results(0, 16, 2, 0, 1, 0);
    check("final_no_stray_writes", bad_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
